cond_branch_resolver: RTL and testbench
=======================================

# cond_branch_resolver

Consumes the Z/C/V/N flags produced by the ALU's subtract/compare path and resolves conditional branches against them. It holds the architectural flags register, tracks whether a flags-setting ALU operation is still in flight, and evaluates one branch request at a time. Requests arrive over a valid/ready handshake; each result is a taken/not-taken decision plus a target address, returned over a second valid/ready handshake. The block sits between decode and the fetch redirect logic, downstream of `Alu`.

## Interface
- `ADDR_WIDTH`, default `` `CPU_ADDR_BUS_MSB_POS+1 ``: width of the PC and the branch target.
- `OFFS_WIDTH`, default `` `CPU_WORD_WIDTH ``: width of the signed branch offset.
- `clk  in  1`: the single clock.
- `rst  in  1`: reset. Synchronous and active-high; all state is cleared on the rising edge of `clk` while it is high.
- `flags_we  in  1`: write the flags register from `flags_in`.
- `flags_in  in  4`: ALU `flags_out`, indexed by `pkg_cpu::FlagZ/FlagC/FlagV/FlagN`.
- `flags_pend  in  1`: a flags-setting ALU operation has been issued and its flags are not yet written.
- `req_valid  in  1`: a branch request is present.
- `req_ready  out  1`: the block can accept a request.
- `req_cond  in  4`: condition code of the request.
- `req_pc  in  ADDR_WIDTH`: PC of the branch.
- `req_offs  in  OFFS_WIDTH`: signed offset.
- `res_valid  out  1`: a result is present.
- `res_ready  in  1`: the consumer accepts the result.
- `res_taken  out  1`: the branch is taken.
- `res_target  out  ADDR_WIDTH`: branch target when taken, `req_pc` when not taken.
- `res_bad_cond  out  1`: the condition code is reserved.

## Operation
- Condition codes (`pkg_cpu::CondCode`) and their taken rule:
  - 0 AL: always; 1 NV: never.
  - 2 EQ: Z; 3 NE: !Z.
  - 4 LTU: !C; 5 LEU: !C | Z; 6 GTU: C & !Z; 7 GEU: C.
  - 8 LT: N!=V; 9 LE: (N!=V) | Z; 10 GT: (N==V) & !Z; 11 GE: N==V.
  - 12–15: reserved. The result is not taken and `res_bad_cond` is 1.
- Target arithmetic:
  - `req_pc + sign_extend(req_offs)`, truncated modulo 2^ADDR_WIDTH; wrap-around is silent.
  - `req_offs` is truncated if `OFFS_WIDTH > ADDR_WIDTH`.
- Pending scoreboard `pend_q`:
  - Set by `flags_pend`; cleared by `flags_we`.
  - If both are high in the same cycle, `pend_q` stays 1, because a new operation has been issued.
- Flag source for evaluation: if `flags_we` is high in the evaluating cycle, `flags_in` is used (forwarding). Otherwise the flags register is used.
- FSM states:
  - IDLE: `req_ready` = 1. On `req_valid`, latch cond, pc and offs. If `pend_q` = 0 or `flags_we` = 1, evaluate now and go to HOLD. Otherwise go to WAIT.
  - WAIT: `req_ready` = 0. On the first cycle with `flags_we`, evaluate using `flags_in` and go to HOLD.
  - HOLD: `res_valid` = 1 and the outputs are stable. On `res_ready`, go to IDLE.
- Requests are never dropped or reordered; only one is outstanding at a time.

## Timing
- Reset values:
  - `res_valid`, `res_taken`, `res_bad_cond`: 0.
  - `res_target`: 0.
  - `req_ready`: 1.
  - Flags register: 0000.
  - `pend_q`: 0.
  - State: IDLE.
- Latency with no pending flags: request accepted in cycle N, `res_valid` high in cycle N+1.
- Latency with pending flags: `res_valid` is high the cycle after the `flags_we` that clears the stall.
- Throughput: with `res_ready` tied high, one result every 2 cycles, because `req_ready` is 0 in HOLD.
- Reset asserted mid-WAIT or mid-HOLD: the request is discarded and no result is produced.
- `flags_pend` arriving in the same cycle as an accepted request: the request evaluates against current flags. Ordering is the issuer's responsibility.

## Configuration
- `CPU_BRANCH_STATS_EN` defined:
  - Adds `stat_taken out 16` and `stat_not_taken out 16`.
  - Each counter increments once per result handshake (`res_valid & res_ready`).
  - Counters saturate at 16'hFFFF and reset to 0.
- Macro undefined: these ports and counters do not exist.

## Structure
- `pkg_cpu` holds:
  - the `CondCode` enum;
  - the FSM state enum;
  - `StrcInBranch` (cond, pc, offs) and `StrcOutBranch` (taken, target, bad_cond).
- One combinational sub-module, `cond_eval`: inputs cond and 4 flags; outputs taken and bad_cond. It is reused by the verification bench as the golden model.

## Test plan
- Flags from a 3−5 subtract (Z=0, C=0, N=1, V=0), no pending; cond LTU, pc=0x100, offs=0x10.
  - Response: result next cycle, taken, target 0x110.
- Same flags, cond GE. Response: not taken, target 0x100.
- Pending stall:
  - Stimulus: `flags_pend` pulse, then request cond EQ; 3 cycles later `flags_we` with Z=1.
  - Response: `req_ready` = 0 during the wait; result 1 cycle after `flags_we`; taken.
- Wrap-around: pc=0xFFFF…FFF0 (all ones except the low nibble), offs=0x20. Response: target 0x10.
- Backpressure and reset:
  - Hold `res_ready` = 0 for 5 cycles. Response: outputs stable, `req_ready` = 0.
  - Assert `rst` while held. Response: `res_valid` = 0 and `req_ready` = 1 next cycle.
- Reserved cond 13. Response: not taken, `res_bad_cond` = 1.
- With `CPU_BRANCH_STATS_EN` defined: after these scenarios, `stat_taken` and `stat_not_taken` match the handshake counts.

Source files
------------

// File: rtl/cond_branch_resolver_pkg.sv
// Shared types for the conditional branch resolver: condition codes, FSM states, request/result records.
// Supplies default bus widths when the CPU-wide width macros are not already defined.
`ifndef CPU_ADDR_BUS_MSB_POS
`define CPU_ADDR_BUS_MSB_POS 31
`endif
`ifndef CPU_WORD_WIDTH
`define CPU_WORD_WIDTH 32
`endif

package pkg_cpu;
  localparam int FlagZ = 0;
  localparam int FlagC = 1;
  localparam int FlagV = 2;
  localparam int FlagN = 3;

  localparam int CPU_ADDR_W = `CPU_ADDR_BUS_MSB_POS + 1;
  localparam int CPU_OFFS_W = `CPU_WORD_WIDTH;

  typedef enum logic [3:0] {
    CondAL  = 4'd0,
    CondNV  = 4'd1,
    CondEQ  = 4'd2,
    CondNE  = 4'd3,
    CondLTU = 4'd4,
    CondLEU = 4'd5,
    CondGTU = 4'd6,
    CondGEU = 4'd7,
    CondLT  = 4'd8,
    CondLE  = 4'd9,
    CondGT  = 4'd10,
    CondGE  = 4'd11
  } CondCode;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } BrState;

  typedef struct packed {
    logic [3:0]            cond;
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_OFFS_W-1:0] offs;
  } StrcInBranch;

  typedef struct packed {
    logic                  taken;
    logic [CPU_ADDR_W-1:0] target;
    logic                  bad_cond;
  } StrcOutBranch;
endpackage

// File: rtl/cond_branch_resolver_cond_eval.sv
// Combinational condition evaluator: maps a condition code and Z/C/V/N flags to taken / reserved.
module cond_eval
  import pkg_cpu::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       bad_cond
);
  logic z, c, v, n;

  assign z = flags[FlagZ];
  assign c = flags[FlagC];
  assign v = flags[FlagV];
  assign n = flags[FlagN];

  always_comb begin
    taken    = 1'b0;
    bad_cond = 1'b0;
    case (cond)
      CondAL:  taken = 1'b1;
      CondNV:  taken = 1'b0;
      CondEQ:  taken = z;
      CondNE:  taken = !z;
      CondLTU: taken = !c;
      CondLEU: taken = !c || z;
      CondGTU: taken = c && !z;
      CondGEU: taken = c;
      CondLT:  taken = (n != v);
      CondLE:  taken = (n != v) || z;
      CondGT:  taken = (n == v) && !z;
      CondGE:  taken = (n == v);
      default: bad_cond = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_branch_resolver.sv
// Resolves conditional branches against the ALU flags, stalling while a flags-setting op is in flight.
// Optional CPU_BRANCH_STATS_EN adds saturating taken / not-taken result counters.
`ifndef CPU_ADDR_BUS_MSB_POS
`define CPU_ADDR_BUS_MSB_POS 31
`endif
`ifndef CPU_WORD_WIDTH
`define CPU_WORD_WIDTH 32
`endif

module cond_branch_resolver
  import pkg_cpu::*;
#(
  parameter int ADDR_WIDTH = `CPU_ADDR_BUS_MSB_POS + 1,
  parameter int OFFS_WIDTH = `CPU_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flags_we,
  input  logic [3:0]            flags_in,
  input  logic                  flags_pend,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_cond,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  input  logic [OFFS_WIDTH-1:0] req_offs,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_taken,
  output logic [ADDR_WIDTH-1:0] res_target,
  output logic                  res_bad_cond
`ifdef CPU_BRANCH_STATS_EN
  ,
  output logic [15:0]           stat_taken,
  output logic [15:0]           stat_not_taken
`endif
);
  localparam int EXT_W = (OFFS_WIDTH > ADDR_WIDTH) ? OFFS_WIDTH : ADDR_WIDTH;

  function automatic logic [ADDR_WIDTH-1:0] calc_target(input logic [ADDR_WIDTH-1:0] pc,
                                                        input logic [OFFS_WIDTH-1:0] offs);
    logic signed [EXT_W-1:0] ext;
    ext = EXT_W'($signed(offs));
    return pc + ADDR_WIDTH'(ext);
  endfunction

  BrState       state_q, state_d;
  logic [3:0]   flags_q, flags_eff;
  logic         pend_q;
  StrcInBranch  req_q, cur;
  StrcOutBranch res_q;
  logic         eval, ev_taken, ev_bad;
  logic [ADDR_WIDTH-1:0] cur_pc, ev_target;

  // In IDLE the live request is evaluated directly; in WAIT the latched copy is used.
  always_comb begin
    cur = req_q;
    if (state_q == StIdle) begin
      cur.cond = req_cond;
      cur.pc   = CPU_ADDR_W'(req_pc);
      cur.offs = CPU_OFFS_W'(req_offs);
    end
  end

  assign flags_eff = flags_we ? flags_in : flags_q;
  assign cur_pc    = ADDR_WIDTH'(cur.pc);
  assign ev_target = ev_taken ? calc_target(cur_pc, OFFS_WIDTH'(cur.offs)) : cur_pc;
  assign eval      = ((state_q == StIdle) && req_valid && (!pend_q || flags_we)) ||
                     ((state_q == StWait) && flags_we);

  cond_eval u_eval (
    .cond     (cur.cond),
    .flags    (flags_eff),
    .taken    (ev_taken),
    .bad_cond (ev_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = (!pend_q || flags_we) ? StHold : StWait;
      StWait:  if (flags_we) state_d = StHold;
      StHold:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == StIdle);
    res_valid    = (state_q == StHold);
    res_taken    = res_q.taken;
    res_target   = ADDR_WIDTH'(res_q.target);
    res_bad_cond = res_q.bad_cond;
  end

  // A new flags_pend outranks a same-cycle write: another op has just been issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
      pend_q  <= 1'b0;
      req_q   <= '0;
      res_q   <= '0;
    end else begin
      if (flags_we) flags_q <= flags_in;
      pend_q <= flags_pend || (pend_q && !flags_we);
      if ((state_q == StIdle) && req_valid) req_q <= cur;
      if (eval) begin
        res_q.taken    <= ev_taken;
        res_q.target   <= CPU_ADDR_W'(ev_target);
        res_q.bad_cond <= ev_bad;
      end
    end
  end

`ifdef CPU_BRANCH_STATS_EN
  logic [15:0] stat_taken_q, stat_not_taken_q;
  logic        res_hs;

  assign res_hs = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_q     <= 16'h0000;
      stat_not_taken_q <= 16'h0000;
    end else if (res_hs) begin
      if (res_q.taken && (stat_taken_q != 16'hFFFF))
        stat_taken_q <= stat_taken_q + 16'h0001;
      if (!res_q.taken && (stat_not_taken_q != 16'hFFFF))
        stat_not_taken_q <= stat_not_taken_q + 16'h0001;
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`endif
endmodule

// File: tb/tb_cond_branch_resolver.sv
// Directed bench for cond_branch_resolver: a vector table of single-cycle branches plus stall/reset sequences.
module tb_cond_branch_resolver;
  localparam int AW = 32;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flags_we = 1'b0;
  logic [3:0]    flags_in = 4'b0000;
  logic          flags_pend = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_cond = 4'd0;
  logic [AW-1:0] req_pc = '0;
  logic [OW-1:0] req_offs = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_taken;
  logic [AW-1:0] res_target;
  logic          res_bad_cond;
`ifdef CPU_BRANCH_STATS_EN
  logic [15:0]   stat_taken, stat_not_taken;
`endif

  cond_branch_resolver #(.ADDR_WIDTH(AW), .OFFS_WIDTH(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flags_we     (flags_we),
    .flags_in     (flags_in),
    .flags_pend   (flags_pend),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cond     (req_cond),
    .req_pc       (req_pc),
    .req_offs     (req_offs),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .res_bad_cond (res_bad_cond)
`ifdef CPU_BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    flags;   // {N,V,C,Z}
    logic [3:0]    cond;
    logic [AW-1:0] pc;
    logic [OW-1:0] offs;
    logic          taken;
    logic [AW-1:0] target;
    logic          bad;
  } vec_t;

  vec_t vecs[20];
  int   total = 0;
  int   bad = 0;
  int   exp_taken_cnt = 0;
  int   exp_nt_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_flags(input logic [3:0] f);
    flags_we = 1'b1;
    flags_in = f;
    @(negedge clk);
    flags_we = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] c, input logic [AW-1:0] pc, input logic [OW-1:0] offs);
    req_valid = 1'b1;
    req_cond  = c;
    req_pc    = pc;
    req_offs  = offs;
  endtask

  task automatic handshake(input logic exp_taken);
    res_ready = 1'b1;
    if (exp_taken) exp_taken_cnt++;
    else           exp_nt_cnt++;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    write_flags(v.flags);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1'b1));
    drive_req(v.cond, v.pc, v.offs);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(1'b1));
    chk({tag, "_taken"}, 64'(res_taken), 64'(v.taken));
    chk({tag, "_target"}, 64'(res_target), 64'(v.target));
    chk({tag, "_bad_cond"}, 64'(res_bad_cond), 64'(v.bad));
    handshake(v.taken);
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 4'd4,  32'h100, 32'h10,       1'b1, 32'h110, 1'b0};
    vecs[1]  = '{4'b1000, 4'd11, 32'h100, 32'h10,       1'b0, 32'h100, 1'b0};
    vecs[2]  = '{4'b1000, 4'd8,  32'h100, 32'hFFFFFFFC, 1'b1, 32'h0FC, 1'b0};
    vecs[3]  = '{4'b1000, 4'd6,  32'h100, 32'h10,       1'b0, 32'h100, 1'b0};
    vecs[4]  = '{4'b0011, 4'd2,  32'h200, 32'h8,        1'b1, 32'h208, 1'b0};
    vecs[5]  = '{4'b0011, 4'd3,  32'h200, 32'h8,        1'b0, 32'h200, 1'b0};
    vecs[6]  = '{4'b0011, 4'd5,  32'h200, 32'h8,        1'b1, 32'h208, 1'b0};
    vecs[7]  = '{4'b0011, 4'd6,  32'h200, 32'h8,        1'b0, 32'h200, 1'b0};
    vecs[8]  = '{4'b0000, 4'd0,  32'h300, 32'h40,       1'b1, 32'h340, 1'b0};
    vecs[9]  = '{4'b0000, 4'd1,  32'h300, 32'h40,       1'b0, 32'h300, 1'b0};
    vecs[10] = '{4'b1100, 4'd11, 32'h400, 32'hFFFFFFF0, 1'b1, 32'h3F0, 1'b0};
    vecs[11] = '{4'b1100, 4'd10, 32'h400, 32'h4,        1'b1, 32'h404, 1'b0};
    vecs[12] = '{4'b1100, 4'd9,  32'h400, 32'h4,        1'b0, 32'h400, 1'b0};
    vecs[13] = '{4'b1100, 4'd7,  32'h400, 32'h4,        1'b0, 32'h400, 1'b0};
    vecs[14] = '{4'b0000, 4'd0,  32'hFFFFFFF0, 32'h20,  1'b1, 32'h010, 1'b0};
    vecs[15] = '{4'b0000, 4'd13, 32'h500, 32'h4,        1'b0, 32'h500, 1'b1};
    vecs[16] = '{4'b0110, 4'd8,  32'h600, 32'h8,        1'b1, 32'h608, 1'b0};
    vecs[17] = '{4'b0010, 4'd4,  32'h600, 32'h8,        1'b0, 32'h600, 1'b0};
    vecs[18] = '{4'b1111, 4'd15, 32'h700, 32'h8,        1'b0, 32'h700, 1'b1};
    vecs[19] = '{4'b0101, 4'd9,  32'h700, 32'h8,        1'b1, 32'h708, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_res_valid", 64'(res_valid), 64'(1'b0));
    chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
    chk("rst_taken", 64'(res_taken), 64'(1'b0));
    chk("rst_target", 64'(res_target), 64'(0));
    chk("rst_bad_cond", 64'(res_bad_cond), 64'(1'b0));

    // Backpressure for 5 cycles, then reset while holding.
    write_flags(4'b1000);
    drive_req(4'd4, 32'h100, 32'h10);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_hold", i),
          64'({res_valid, req_ready, res_taken, res_target}), 64'({1'b1, 1'b0, 1'b1, 32'h110}));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("bp_rst_res_valid", 64'(res_valid), 64'(1'b0));
    chk("bp_rst_req_ready", 64'(req_ready), 64'(1'b1));

    // Reset during WAIT discards the request.
    flags_pend = 1'b1;
    @(negedge clk);
    flags_pend = 1'b0;
    drive_req(4'd0, 32'h100, 32'h4);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wrst_req_ready", 64'(req_ready), 64'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wrst_idle", 64'({res_valid, req_ready}), 64'({1'b0, 1'b1}));
    write_flags(4'b0001);
    chk("wrst_no_result", 64'(res_valid), 64'(1'b0));

    for (int i = 0; i < 20; i++) do_vec(vecs[i], i);

    // Forwarding: flags_we in the accept cycle overrides the stale register.
    write_flags(4'b0000);
    flags_we = 1'b1;
    flags_in = 4'b0001;
    drive_req(4'd2, 32'h800, 32'h4);
    @(negedge clk);
    flags_we = 1'b0;
    req_valid = 1'b0;
    chk("fwd_res_valid", 64'(res_valid), 64'(1'b1));
    chk("fwd_taken", 64'({res_taken, res_target}), 64'({1'b1, 32'h804}));
    handshake(1'b1);

    // Pending stall: EQ waits until flags_we delivers Z=1.
    write_flags(4'b0000);
    flags_pend = 1'b1;
    @(negedge clk);
    flags_pend = 1'b0;
    drive_req(4'd2, 32'h900, 32'h10);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d", i), 64'({req_ready, res_valid}), 64'({1'b0, 1'b0}));
      if (i < 2) @(negedge clk);
    end
    flags_we = 1'b1;
    flags_in = 4'b0001;
    @(negedge clk);
    flags_we = 1'b0;
    chk("stall_res_valid", 64'(res_valid), 64'(1'b1));
    chk("stall_taken", 64'({res_taken, res_target}), 64'({1'b1, 32'h910}));
    handshake(1'b1);

    // flags_pend together with an accepted request: evaluates against current flags.
    flags_pend = 1'b1;
    drive_req(4'd3, 32'hA00, 32'h4);
    @(negedge clk);
    flags_pend = 1'b0;
    req_valid = 1'b0;
    chk("pendsame_res_valid", 64'(res_valid), 64'(1'b1));
    chk("pendsame_taken", 64'({res_taken, res_target}), 64'({1'b0, 32'hA00}));
    handshake(1'b0);
    write_flags(4'b0000);
    chk("pendsame_idle", 64'({req_ready, res_valid}), 64'({1'b1, 1'b0}));

`ifdef CPU_BRANCH_STATS_EN
    chk("stat_taken", 64'(stat_taken), 64'(exp_taken_cnt));
    chk("stat_not_taken", 64'(stat_not_taken), 64'(exp_nt_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
